// File: rtl/bft_pkg.sv
// Shared BFT packet layout and bridge constants: field offsets/widths, kind
// encodings, the control port and the credit window a bridge starts with.
package bft_pkg;

  localparam int PKT_W     = 49;
  localparam int PAYLOAD_W = 32;
  localparam int LEAF_W    = 4;
  localparam int PORT_W    = 4;
  localparam int ADDR_W    = 7;

  localparam int VALID_BIT = 48;
  localparam int LEAF_LSB  = 44;
  localparam int PORT_LSB  = 40;
  localparam int ADDR_LSB  = 33;
  localparam int KIND_BIT  = 32;

  localparam logic KIND_DATA   = 1'b0;
  localparam logic KIND_UPDATE = 1'b1;

  localparam logic [3:0] CTRL_PORT     = 4'd0;
  localparam logic [7:0] INIT_CREDITS  = 8'd128;
  localparam int         RX_FIFO_DEPTH = 128;

endpackage

// File: rtl/bft_sync_fifo.sv
// Synchronous FIFO with a registered output stage; the output register counts
// as one of the DEPTH slots, so the backing memory only ever holds DEPTH-1.
module bft_sync_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 128
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             wr_drop
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr, mem_count;
  logic             full, pop, wr_ok, refill, mem_to_out, bypass, wr_to_mem;

  assign full       = rd_valid && (mem_count == AW'(DEPTH - 1));
  assign pop        = rd_valid && rd_en;
  // A pop in the same cycle frees a slot, so a write at full still lands.
  assign wr_ok      = wr_en && (!full || pop);
  assign wr_drop    = wr_en && !wr_ok;
  assign refill     = !rd_valid || pop;
  assign mem_to_out = refill && (mem_count != '0);
  assign bypass     = refill && (mem_count == '0) && wr_ok;
  assign wr_to_mem  = wr_ok && !bypass;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      mem_count <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
    end else begin
      if (mem_to_out) begin
        rd_data  <= mem[rd_ptr];
        rd_valid <= 1'b1;
        rd_ptr   <= rd_ptr + 1'b1;
      end else if (bypass) begin
        rd_data  <= wr_data;
        rd_valid <= 1'b1;
      end else if (pop) begin
        rd_valid <= 1'b0;
      end
      if (wr_to_mem) wr_ptr <= wr_ptr + 1'b1;
      mem_count <= mem_count + AW'(wr_to_mem) - AW'(mem_to_out);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_to_mem) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/bft_host_bridge.sv
// Host-side BFT bridge: packs host words into credit-limited BFT packets and
// unpacks packets for this leaf into a host stream, returning credits per 64 pops.
module bft_host_bridge
  import bft_pkg::*;
#(
  parameter int PACKET_BITS           = PKT_W,
  parameter int PAYLOAD_BITS          = PAYLOAD_W,
  parameter int NUM_LEAF_BITS         = LEAF_W,
  parameter int NUM_PORT_BITS         = PORT_W,
  parameter int NUM_ADDR_BITS         = ADDR_W,
  parameter int FREESPACE_UPDATE_SIZE = 64,
  parameter int SELF_LEAF             = 0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_LEAF_BITS-1:0] dst_leaf,
  input  logic [NUM_PORT_BITS-1:0] dst_port,
  input  logic [PAYLOAD_BITS-1:0]  s_tdata,
  input  logic                     s_tvalid,
  output logic                     s_tready,
  output logic [PAYLOAD_BITS-1:0]  m_tdata,
  output logic [NUM_PORT_BITS-1:0] m_tport,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic [PACKET_BITS-1:0]   dout_host2bft,
  input  logic [PACKET_BITS-1:0]   din_bft2host,
  output logic [7:0]               tx_credits,
  output logic                     rx_overflow
);

  // Both streams use valid/ready: a word moves on a rising edge where valid and
  // ready are both high; the source holds its data stable while valid && !ready.

  localparam int RX_W  = NUM_PORT_BITS + PAYLOAD_BITS;
  localparam int POP_W = $clog2(FREESPACE_UPDATE_SIZE + 1);
  localparam logic [POP_W-1:0] POP_LAST = POP_W'(FREESPACE_UPDATE_SIZE - 1);

  logic                     din_mine, upd_in, data_in, unused_addr;
  logic [NUM_ADDR_BITS-1:0] tx_addr;
  logic [1:0]               upd_pending;
  logic                     send_upd, send_data;
  logic [9:0]               credit_next;
  logic                     rx_wr_en, rx_drop, pop, pop_wrap;
  logic [RX_W-1:0]          rx_wr_data, rx_rd_data;
  logic [POP_W-1:0]         pop_cnt;

  assign din_mine = din_bft2host[VALID_BIT] &&
                    (din_bft2host[LEAF_LSB +: NUM_LEAF_BITS] == NUM_LEAF_BITS'(SELF_LEAF));
  assign upd_in      = din_mine && (din_bft2host[KIND_BIT] == KIND_UPDATE);
  assign data_in     = din_mine && (din_bft2host[KIND_BIT] == KIND_DATA);
  assign unused_addr = ^din_bft2host[ADDR_LSB +: NUM_ADDR_BITS];

  assign s_tready  = reset_n && (tx_credits != 8'd0) && (upd_pending == 2'd0);
  assign send_upd  = (upd_pending != 2'd0);
  assign send_data = s_tvalid && s_tready;

  always_comb begin
    credit_next = {2'b00, tx_credits};
    if (upd_in)    credit_next = credit_next + {2'b00, din_bft2host[7:0]};
    if (send_data) credit_next = credit_next - 10'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout_host2bft <= '0;
      tx_addr       <= '0;
      tx_credits    <= INIT_CREDITS;
    end else begin
      tx_credits <= (credit_next > {2'b00, INIT_CREDITS}) ? INIT_CREDITS : credit_next[7:0];
      if (send_upd) begin
        dout_host2bft <= {1'b1, dst_leaf, NUM_PORT_BITS'(CTRL_PORT), {NUM_ADDR_BITS{1'b0}},
                          KIND_UPDATE, PAYLOAD_BITS'(FREESPACE_UPDATE_SIZE)};
      end else if (send_data) begin
        dout_host2bft <= {1'b1, dst_leaf, dst_port, tx_addr, KIND_DATA, s_tdata};
        tx_addr       <= tx_addr + 1'b1;
      end else begin
        dout_host2bft <= '0;
      end
    end
  end

  assign pop      = m_tvalid && m_tready;
  assign pop_wrap = pop && (pop_cnt == POP_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_wr_en    <= 1'b0;
      rx_wr_data  <= '0;
      rx_overflow <= 1'b0;
      pop_cnt     <= '0;
      upd_pending <= 2'd0;
    end else begin
      rx_wr_en   <= data_in;
      rx_wr_data <= {din_bft2host[PORT_LSB +: NUM_PORT_BITS], din_bft2host[PAYLOAD_BITS-1:0]};
      if (rx_drop) rx_overflow <= 1'b1;
      if (pop) pop_cnt <= pop_wrap ? '0 : pop_cnt + 1'b1;
      // An update leaves every cycle pending is nonzero, so this never passes 3.
      upd_pending <= upd_pending + {1'b0, pop_wrap} - {1'b0, send_upd};
    end
  end

  bft_sync_fifo #(
    .WIDTH (RX_W),
    .DEPTH (RX_FIFO_DEPTH)
  ) u_rx_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en    (rx_wr_en),
    .wr_data  (rx_wr_data),
    .rd_en    (m_tready),
    .rd_data  (rx_rd_data),
    .rd_valid (m_tvalid),
    .wr_drop  (rx_drop)
  );

  assign m_tport = rx_rd_data[RX_W-1 -: NUM_PORT_BITS];
  assign m_tdata = rx_rd_data[PAYLOAD_BITS-1:0];

endmodule
